// File: rtl/md_unit_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
package md_unit_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {S_IDLE, S_RUN} md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Codes 0..3 occupy the multi-cycle unit; 4..7 do not.
  function automatic logic is_arith(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/md_unit_ctrl_md_arith.sv
// Combinational multiply/divide datapath: signedness and division corner
// cases live here so the sequencer only deals with timing.
module md_arith
  import md_unit_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        div_zero
);

  logic [31:0] dv, ma, mb, mbd, uq, ur, mq, mr, sq, sr;

  // Signed division goes through magnitudes, so 0x8000_0000 / -1 yields
  // 0x8000_0000 with no overflow special case. A zero divisor is swapped for
  // 1 to keep the dividers defined; the result is dropped via div_zero.
  always_comb begin
    dv  = (b == 32'd0) ? 32'd1 : b;
    ma  = a[31] ? -a : a;
    mb  = b[31] ? -b : b;
    mbd = (mb == 32'd0) ? 32'd1 : mb;
    uq  = a / dv;
    ur  = a % dv;
    mq  = ma / mbd;
    mr  = ma % mbd;
    sq  = (a[31] ^ b[31]) ? -mq : mq;
    sr  = a[31] ? -mr : mr;
  end

  // Select the 64-bit {hi, lo} result for the requested operation.
  always_comb begin
    res      = '0;
    div_zero = is_arith(op) & op[1] & (b == 32'd0);
    case (op)
      MD_MULT:  res = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      MD_MULTU: res = {32'd0, a} * {32'd0, b};
      MD_DIV:   res = {sr, sq};
      MD_DIVU:  res = {ur, uq};
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/md_unit_ctrl.sv
// HI/LO sequencer: latches a mul/div result, waits a fixed latency, then
// commits to HI/LO while requesting ID-stage stalls for HI/LO users.
module md_unit_ctrl
  import md_unit_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        id_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  md_state_e   state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] res_hi, res_lo;
  logic        res_dz;
  logic        is_md, accept, commit;
  logic [63:0] ar_res;
  logic        ar_dz;

  md_arith u_arith (
    .op       (md_op),
    .a        (rs_data),
    .b        (rt_data),
    .res      (ar_res),
    .div_zero (ar_dz)
  );

  assign is_md = start & is_arith(md_op);
  assign busy  = (state == S_RUN);
  assign stall = id_md_use & (busy | is_md);

  // Next state / counter. A new op is taken on the final busy edge too, so
  // back-to-back ops complete every N cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (is_md) begin
          accept    = 1'b1;
          cnt_nxt   = md_op[1] ? DIV_N : MULT_N;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          commit    = 1'b1;
          state_nxt = S_IDLE;
          if (is_md) begin
            accept    = 1'b1;
            cnt_nxt   = md_op[1] ? DIV_N : MULT_N;
            state_nxt = S_RUN;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and latency counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Pending result capture, HI/LO commit and MTHI/MTLO writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_hi <= '0;
      res_lo <= '0;
      res_dz <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      if (accept) begin
        res_hi <= ar_res[63:32];
        res_lo <= ar_res[31:0];
        res_dz <= ar_dz;
      end
      if (commit && !res_dz) begin
        hi <= res_hi;
        lo <= res_lo;
      end
      if (state == S_IDLE && start && md_op == MD_MTHI) hi <= rs_data;
      if (state == S_IDLE && start && md_op == MD_MTLO) lo <= rs_data;
    end
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: spec-level model compared every
// cycle, plus hand-computed expectations for the directed cases.
module tb_md_unit_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk, reset, start, id_md_use;
  logic [2:0]  md_op;
  logic [31:0] rs_data, rt_data;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  md_unit_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .md_op     (md_op),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .id_md_use (id_md_use),
    .busy      (busy),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        p_skip = 1'b0;
  int          m_rem = 0;

  task automatic m_launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p_skip = 1'b0;
    p = '0;
    case (op)
      3'd0: p = 64'(sa * sb);
      3'd1: p = 64'(a) * 64'(b);
      3'd2: if (b == 0) p_skip = 1'b1;
            else begin q = sa / sb; r = sa % sb; p = {32'(r), 32'(q)}; end
      default: if (b == 0) p_skip = 1'b1;
               else p = {a % b, a / b};
    endcase
    p_hi  = p[63:32];
    p_lo  = p[31:0];
    m_rem = (op < 3'd2) ? MC : DC;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi = '0; m_lo = '0; m_rem = 0; p_skip = 1'b0;
    end else begin
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          if (!p_skip) begin m_hi = p_hi; m_lo = p_lo; end
          if (start && md_op <= 3'd3) m_launch(md_op, rs_data, rt_data);
        end
      end else if (start && md_op <= 3'd3) m_launch(md_op, rs_data, rt_data);
      else if (start && md_op == 3'd4) m_hi = rs_data;
      else if (start && md_op == 3'd5) m_lo = rs_data;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_rem > 0));
    chk("stall", 32'(stall), 32'(id_md_use && (m_rem > 0 || (start && md_op <= 3'd3))));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  end

  // ---------------- stimulus ----------------
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_i, output int cyc, output int stc, output logic st0);
    @(posedge clk); #1;
    start = 1'b1; md_op = op; rs_data = a; rt_data = b; id_md_use = use_i;
    @(negedge clk); st0 = stall;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd7;
    cyc = 0; stc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
      if (stall) stc++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, stc;
    logic st0;
    reset = 1'b0; start = 1'b0; md_op = 3'd7; rs_data = '0; rt_data = '0; id_md_use = 1'b1;
    #23;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    reset = 1'b1;

    // MULT -2 * 3 with a HI/LO user in ID every cycle
    run_op(3'd0, 32'hFFFF_FFFE, 32'h3, 1'b1, cyc, stc, st0);
    chk("mult_cyc", 32'(cyc), 32'd5);
    chk("mult_st0", 32'(st0), 32'd1);
    chk("mult_stc", 32'(stc), 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    chk("mult_stall_after", 32'(stall), 32'd0);

    // MULTU same operands, no HI/LO user
    run_op(3'd1, 32'hFFFF_FFFE, 32'h3, 1'b0, cyc, stc, st0);
    chk("multu_cyc", 32'(cyc), 32'd5);
    chk("multu_stall", 32'(stc + int'(st0)), 32'd0);
    chk("multu_hi", hi, 32'h2);
    chk("multu_lo", lo, 32'hFFFF_FFFA);

    // DIV -7 / 2
    run_op(3'd2, 32'hFFFF_FFF9, 32'h2, 1'b1, cyc, stc, st0);
    chk("div_cyc", 32'(cyc), 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // DIV overflow corner
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, cyc, stc, st0);
    chk("divov_lo", lo, 32'h8000_0000);
    chk("divov_hi", hi, 32'h0);

    // MTHI/MTLO preload then DIVU by zero
    run_op(3'd4, 32'h11, 32'h0, 1'b0, cyc, stc, st0);
    chk("mthi_cyc", 32'(cyc), 32'd0);
    run_op(3'd5, 32'h22, 32'h0, 1'b0, cyc, stc, st0);
    run_op(3'd3, 32'd100, 32'h0, 1'b0, cyc, stc, st0);
    chk("dz_cyc", 32'(cyc), 32'd10);
    chk("dz_hi", hi, 32'h11);
    chk("dz_lo", lo, 32'h22);

    // MTHI then MULT 7 * -3
    run_op(3'd4, 32'hDEAD_BEEF, 32'h0, 1'b1, cyc, stc, st0);
    chk("mthi2_cyc", 32'(cyc), 32'd0);
    chk("mthi2_hi", hi, 32'hDEAD_BEEF);
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, cyc, stc, st0);
    chk("mult2_cyc", 32'(cyc), 32'd5);
    chk("mult2_hi", hi, 32'hFFFF_FFFF);
    chk("mult2_lo", lo, 32'hFFFF_FFEB);

    // Back-to-back: MULTU then DIVU issued on the final busy edge
    @(posedge clk); #1;
    start = 1'b1; md_op = 3'd1; rs_data = 32'h1_0000; rt_data = 32'h1_0000;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd7;
    repeat (MC - 1) @(posedge clk);
    #1;
    start = 1'b1; md_op = 3'd3; rs_data = 32'd100; rt_data = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd7;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_hi1", hi, 32'h1);
    chk("b2b_lo1", lo, 32'h0);
    cyc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
    end
    chk("b2b_cyc2", 32'(cyc), 32'd10);
    chk("b2b_lo2", lo, 32'd14);
    chk("b2b_hi2", hi, 32'd2);

    // Asynchronous reset in the middle of a DIV
    @(posedge clk); #1;
    start = 1'b1; md_op = 3'd2; rs_data = 32'd1000; rt_data = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd7;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    #3 reset = 1'b1;
    run_op(3'd0, 32'd6, 32'd7, 1'b0, cyc, stc, st0);
    chk("post_cyc", 32'(cyc), 32'd5);
    chk("post_hi", hi, 32'h0);
    chk("post_lo", lo, 32'd42);

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_unit_ctrl.md
# md_unit_ctrl

Sequencer for the multi-cycle multiply/divide resource next to the EX-stage ALU. It latches operands from the EX stage, counts a fixed latency, and commits the 64-bit result to the HI/LO registers. While the unit is busy, it raises a stall request toward the ID stage for any instruction that touches HI/LO. The ALU path stays single-cycle; this block owns all HI/LO state and timing.

## Interface
Parameters:
- MULT_CYCLES, default 5: busy cycles for MULT/MULTU; legal range 1–15.
- DIV_CYCLES, default 10: busy cycles for DIV/DIVU; legal range 1–15.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; asserting it clears all state.
- start  in  1  EX stage holds a valid HI/LO instruction this cycle.
- md_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 are no-op.
- rs_data  in  32  forwarded Rs operand (dividend / multiplicand / MT source).
- rt_data  in  32  forwarded Rt operand (divisor / multiplier).
- id_md_use  in  1  ID-stage instruction is any of MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
- busy  out  1  an operation is in flight.
- stall  out  1  combinational hold request for PC/IF/ID.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- States: IDLE and RUN; a 4-bit counter `cnt`.
- IDLE with start and md_op in 0–3:
  - Capture the operation's result into pending registers `res_hi`/`res_lo`.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES, then enter RUN.
- RUN: `cnt` decrements each edge.
  - At the edge where `cnt`==1: `hi<=res_hi`, `lo<=res_lo`, return to IDLE.
- IDLE with start and md_op 4 or 5: write `rs_data` into `hi` or `lo` respectively at that edge; stay in IDLE.
- start while in RUN: ignored; the stall makes this unreachable in a correct pipeline.
- md_op 6–7: no effect.
- Arithmetic:
  - MULT: signed 32x32→64. MULTU: unsigned 32x32→64. HI gets bits 63:32, LO gets bits 31:0.
  - DIV: LO = quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Divisor zero: HI/LO keep their prior values, but the full busy period still elapses.
  - DIV of 0x8000_0000 by 0xFFFF_FFFF: LO=0x8000_0000, HI=0.
- stall = id_md_use & (busy | (start & md_op<=3)).
- Reset values: hi=0, lo=0, busy=0, state=IDLE, `cnt`=0. stall=0 whenever id_md_use=0.
- Reset asserted mid-operation: the pending result is discarded and HI/LO clear to 0.

## Timing
- Start sampled at edge t0: busy is high from just after t0 through edge t0+N, where N is the op's cycle count.
- hi/lo show the new value right after edge t0+N, the same edge that drops busy.
- A start can be accepted at t0+N, so back-to-back ops complete every N cycles.
- MTHI/MTLO: 1-cycle latency; busy stays 0.
- MFHI/MFLO read `hi`/`lo` directly, with no bypass of pending results. The stall guarantees they never observe a stale value.
- stall has no register stage; it is purely combinational from start, md_op, id_md_use and busy.

## Structure
- Shared parameter include, alongside the existing CPU parameter file:
  - md_op codes MD_MULT … MD_MTLO.
  - Default MULT_CYCLES / DIV_CYCLES.
- One combinational sub-module, `md_arith`:
  - Inputs: op, a, b. Outputs: 64-bit result and a div-by-zero flag.
  - Keeps signed/unsigned and division corner cases out of the FSM.
- The top level holds only the FSM, the counter, the pending registers and HI/LO.

## Test plan
- MULT 0xFFFF_FFFE × 0x0000_0003 → busy for 5 cycles, then hi=0xFFFF_FFFF, lo=0xFFFF_FFFA. With MULTU on the same operands → hi=0x0000_0002, lo=0xFFFF_FFFA.
- DIV −7 (0xFFFF_FFF9) by 2 → after 10 cycles lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIV 0x8000_0000 by −1 → lo=0x8000_0000, hi=0.
- DIVU 100 by 0, with prior hi=0x11, lo=0x22 → busy still spans 10 cycles; hi/lo remain 0x11/0x22.
- Start MULT with id_md_use=1 every cycle → stall=1 on the start cycle and all 5 busy cycles, then 0. With id_md_use=0, stall stays 0 throughout.
- MTHI 0xDEAD_BEEF → hi updates after one edge and busy never rises. A MULT issued the next cycle completes normally.
- Drop reset (active-low) at cycle 3 of a DIV → hi=lo=0, busy=0 immediately, without waiting for a clock edge. After reset releases, a new MULT runs its full 5 cycles.
